sgdma_descriptor_fetch: RTL and testbench

- Upstream control stage for the on-chip descriptor RAM (1024 x 32, single-port, 1-cycle read latency) in the board update portal.
- Walks a linked chain of 4-word descriptors held in that RAM and issues one transfer command per descriptor to the data mover.
- Waits for each transfer's completion, then writes status back into the descriptor (OWN cleared, actual byte count, error flag).
- Controlled by a start/stop interface from the CSR block; raises a completion interrupt.

---
 rtl/sgdma_desc_pkg.sv | 40 ++++
 rtl/sgdma_desc_rd_port.sv | 55 +++++
 rtl/sgdma_descriptor_fetch.sv | 218 +++++++++++++++++++++
 tb/tb_sgdma_descriptor_fetch.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgdma_desc_pkg.sv
// Shared constants for the scatter-gather descriptor fetcher: descriptor word
// offsets, CTRL bit positions, FSM state encoding and the write-back word builder.
package sgdma_desc_pkg;

    localparam logic [1:0] SRC_OFS  = 2'd0;
    localparam logic [1:0] DST_OFS  = 2'd1;
    localparam logic [1:0] NEXT_OFS = 2'd2;
    localparam logic [1:0] CTRL_OFS = 2'd3;

    localparam int unsigned OWN_BIT  = 31;
    localparam int unsigned LAST_BIT = 30;
    localparam int unsigned IRQ_BIT  = 29;
    localparam int unsigned ERR_BIT  = 28;
    localparam int unsigned LEN_MSB  = 15;

    typedef enum logic [3:0] {
        StIdle,
        StRd,
        StRdw,
        StCheck,
        StIssue,
        StWaitCmpl,
        StWb,
        StNext,
        StFinish
    } fetch_state_e;

    // OWN is left at 0 so the descriptor is handed back to software.
    function automatic logic [31:0] wb_word(input logic last, input logic irq_en,
                                            input logic err, input logic [15:0] bytes);
        logic [31:0] w;
        w              = '0;
        w[LAST_BIT]    = last;
        w[IRQ_BIT]     = irq_en;
        w[ERR_BIT]     = err;
        w[LEN_MSB:0]   = bytes;
        return w;
    endfunction

endpackage

// File: rtl/sgdma_desc_rd_port.sv
// Single-outstanding Avalon-MM sequencer for the descriptor RAM: holds read/write
// strobes through waitrequest and tracks the one pending read until readdatavalid.
module sgdma_desc_rd_port #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              rd_accept_o,
    output logic              rd_valid_o,
    output logic [31:0]       rd_data_o,
    output logic              wr_accept_o,
    output logic [ADDR_W-1:0] desc_address_o,
    output logic              desc_read_o,
    output logic              desc_write_o,
    output logic [3:0]        desc_byteenable_o,
    output logic [31:0]       desc_writedata_o,
    input  logic              desc_waitrequest_i,
    input  logic              desc_readdatavalid_i,
    input  logic [31:0]       desc_readdata_i
);

    logic pend_q, pend_d;

    always_comb begin
        desc_read_o       = rd_req_i & ~pend_q;
        desc_write_o      = wr_req_i & ~rd_req_i & ~pend_q;
        desc_address_o    = (desc_read_o | desc_write_o) ? addr_i : '0;
        desc_writedata_o  = desc_write_o ? wdata_i : '0;
        desc_byteenable_o = desc_write_o ? 4'b1111 : 4'b0000;
        rd_accept_o       = desc_read_o & ~desc_waitrequest_i;
        wr_accept_o       = desc_write_o & ~desc_waitrequest_i;
        rd_valid_o        = pend_q & desc_readdatavalid_i;
        rd_data_o         = desc_readdata_i;

        pend_d = pend_q;
        if (rd_accept_o) begin
            pend_d = 1'b1;
        end else if (rd_valid_o) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/sgdma_descriptor_fetch.sv
// Walks a linked chain of 4-word descriptors, issues one transfer command per
// descriptor, waits for completion and writes status back into the CTRL word.
module sgdma_descriptor_fetch
    import sgdma_desc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_CHAIN = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] head_ptr,
    output logic              busy,
    output logic              done_irq,
    output logic              run_err,
    output logic [ADDR_W-1:0] desc_address,
    output logic              desc_read,
    output logic              desc_write,
    output logic [3:0]        desc_byteenable,
    output logic [31:0]       desc_writedata,
    input  logic              desc_waitrequest,
    input  logic              desc_readdatavalid,
    input  logic [31:0]       desc_readdata,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [31:0]       cmd_src,
    output logic [31:0]       cmd_dst,
    output logic [15:0]       cmd_len,
    input  logic              cmpl_valid,
    input  logic [15:0]       cmpl_bytes,
    input  logic              cmpl_err
);

    localparam int unsigned CntW = $clog2(MAX_CHAIN + 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d, next_q, next_d;
    logic [1:0]        k_q, k_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       src_q, src_d, dst_q, dst_d;
    logic [15:0]       len_q, len_d, bytes_q, bytes_d;
    logic              own_q, own_d, last_q, last_d, irq_en_q, irq_en_d;
    logic              cerr_q, cerr_d, irq_q, irq_d, run_err_q, run_err_d;

    logic              rd_req, wr_req, rd_accept, rd_valid, wr_accept;
    logic [ADDR_W-1:0] port_addr;
    logic [31:0]       rd_data;

    sgdma_desc_rd_port #(
        .ADDR_W(ADDR_W)
    ) u_port (
        .clk                 (clk),
        .reset_n             (reset_n),
        .rd_req_i            (rd_req),
        .wr_req_i            (wr_req),
        .addr_i              (port_addr),
        .wdata_i             (wb_word(last_q, irq_en_q, cerr_q, bytes_q)),
        .rd_accept_o         (rd_accept),
        .rd_valid_o          (rd_valid),
        .rd_data_o           (rd_data),
        .wr_accept_o         (wr_accept),
        .desc_address_o      (desc_address),
        .desc_read_o         (desc_read),
        .desc_write_o        (desc_write),
        .desc_byteenable_o   (desc_byteenable),
        .desc_writedata_o    (desc_writedata),
        .desc_waitrequest_i  (desc_waitrequest),
        .desc_readdatavalid_i(desc_readdatavalid),
        .desc_readdata_i     (desc_readdata)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        next_d    = next_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        bytes_d   = bytes_q;
        own_d     = own_q;
        last_d    = last_q;
        irq_en_d  = irq_en_q;
        cerr_d    = cerr_q;
        irq_d     = irq_q;
        run_err_d = run_err_q;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        port_addr = cur_q + ADDR_W'(k_q);

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRd;
                    cur_d     = head_ptr & ~ADDR_W'(3);
                    k_d       = 2'd0;
                    cnt_d     = '0;
                    run_err_d = 1'b0;
                end
            end
            StRd: begin
                rd_req = 1'b1;
                if (rd_accept) state_d = StRdw;
            end
            StRdw: begin
                if (rd_valid) begin
                    unique case (k_q)
                        SRC_OFS:  src_d  = rd_data;
                        DST_OFS:  dst_d  = rd_data;
                        NEXT_OFS: next_d = rd_data[ADDR_W-1:0];
                        CTRL_OFS: begin
                            own_d    = rd_data[OWN_BIT];
                            last_d   = rd_data[LAST_BIT];
                            irq_en_d = rd_data[IRQ_BIT];
                            len_d    = rd_data[LEN_MSB:0];
                        end
                    endcase
                    if (k_q == CTRL_OFS) begin
                        state_d = StCheck;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = StRd;
                    end
                end
            end
            StCheck: begin
                if (!own_q || stop) begin
                    state_d = StFinish;
                end else if (cnt_q == CntW'(MAX_CHAIN)) begin
                    // Loop guard: a chain this long is assumed to be a broken link.
                    run_err_d = 1'b1;
                    state_d   = StFinish;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (cmd_ready) state_d = StWaitCmpl;
            end
            StWaitCmpl: begin
                if (cmpl_valid) begin
                    bytes_d = cmpl_bytes;
                    cerr_d  = cmpl_err;
                    state_d = StWb;
                end
            end
            StWb: begin
                wr_req    = 1'b1;
                port_addr = cur_q + ADDR_W'(CTRL_OFS);
                if (wr_accept) state_d = StNext;
            end
            StNext: begin
                cnt_d = cnt_q + CntW'(1);
                irq_d = irq_q | irq_en_q;
                if (cerr_q) run_err_d = 1'b1;
                if (last_q || cerr_q) begin
                    state_d = StFinish;
                end else begin
                    cur_d   = next_q & ~ADDR_W'(3);
                    k_d     = 2'd0;
                    state_d = StRd;
                end
            end
            StFinish: begin
                irq_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            next_q    <= '0;
            k_q       <= 2'd0;
            cnt_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            bytes_q   <= '0;
            own_q     <= 1'b0;
            last_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            cerr_q    <= 1'b0;
            irq_q     <= 1'b0;
            run_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            next_q    <= next_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            bytes_q   <= bytes_d;
            own_q     <= own_d;
            last_q    <= last_d;
            irq_en_q  <= irq_en_d;
            cerr_q    <= cerr_d;
            irq_q     <= irq_d;
            run_err_q <= run_err_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done_irq  = (state_q == StFinish) && (irq_q || run_err_q);
    assign run_err   = run_err_q;
    assign cmd_valid = (state_q == StIssue);
    assign cmd_src   = src_q;
    assign cmd_dst   = dst_q;
    assign cmd_len   = len_q;

endmodule

// File: tb/tb_sgdma_descriptor_fetch.sv
// Directed bench for sgdma_descriptor_fetch: behavioural descriptor RAM and data
// mover, one task per scenario with hand-computed expectations.
module tb_sgdma_descriptor_fetch;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] head_ptr = '0;
    logic          busy, done_irq, run_err;
    logic [AW-1:0] desc_address;
    logic          desc_read, desc_write;
    logic [3:0]    desc_byteenable;
    logic [31:0]   desc_writedata;
    logic          desc_waitrequest = 1'b0;
    logic          desc_readdatavalid = 1'b0;
    logic [31:0]   desc_readdata = '0;
    logic          cmd_valid;
    logic          cmd_ready = 1'b0;
    logic [31:0]   cmd_src, cmd_dst;
    logic [15:0]   cmd_len;
    logic          cmpl_valid = 1'b0;
    logic [15:0]   cmpl_bytes = '0;
    logic          cmpl_err = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sgdma_descriptor_fetch #(
        .ADDR_W   (AW),
        .MAX_CHAIN(4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .stop              (stop),
        .head_ptr          (head_ptr),
        .busy              (busy),
        .done_irq          (done_irq),
        .run_err           (run_err),
        .desc_address      (desc_address),
        .desc_read         (desc_read),
        .desc_write        (desc_write),
        .desc_byteenable   (desc_byteenable),
        .desc_writedata    (desc_writedata),
        .desc_waitrequest  (desc_waitrequest),
        .desc_readdatavalid(desc_readdatavalid),
        .desc_readdata     (desc_readdata),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_src           (cmd_src),
        .cmd_dst           (cmd_dst),
        .cmd_len           (cmd_len),
        .cmpl_valid        (cmpl_valid),
        .cmpl_bytes        (cmpl_bytes),
        .cmpl_err          (cmpl_err)
    );

    // Environment: RAM, loader port, event logs and data-mover model.
    logic [31:0]   mem [1024];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0]   ld_data = '0;
    logic          wr_protect = 1'b0;
    logic          wait_mode = 1'b0;
    int            cmpl_delay = 3;
    int            err_idx = -1;
    logic [15:0]   byte_short = '0;
    int            rd_n = 0, wr_n = 0, cmd_n = 0, irq_n = 0, be_bad = 0;
    logic [AW-1:0] wr_log_addr [64];
    logic [31:0]   wr_log_data [64];
    logic [31:0]   cmd_src_log [64];
    logic [31:0]   cmd_dst_log [64];
    logic [15:0]   cmd_len_log [64];
    int            mv_cnt = 0;
    logic [15:0]   mv_bytes = '0;
    logic          mv_err = 1'b0;

    always @(posedge clk) begin
        desc_readdatavalid <= desc_read && !desc_waitrequest;
        desc_readdata      <= mem[desc_address];
        desc_waitrequest   <= wait_mode ? ~desc_waitrequest : 1'b0;
        if (ld_en) mem[ld_addr] = ld_data;
        if (desc_read && !desc_waitrequest) rd_n++;
        if (desc_write && !desc_waitrequest) begin
            if (desc_byteenable != 4'hF) be_bad++;
            wr_log_addr[wr_n % 64] = desc_address;
            wr_log_data[wr_n % 64] = desc_writedata;
            if (!wr_protect) mem[desc_address] = desc_writedata;
            wr_n++;
        end
        if (done_irq) irq_n++;
        cmpl_valid <= 1'b0;
        if (cmd_valid && cmd_ready) begin
            cmd_src_log[cmd_n % 64] = cmd_src;
            cmd_dst_log[cmd_n % 64] = cmd_dst;
            cmd_len_log[cmd_n % 64] = cmd_len;
            mv_cnt   <= cmpl_delay;
            mv_bytes <= cmd_len - byte_short;
            mv_err   <= (cmd_n == err_idx);
            cmd_n++;
        end else if (mv_cnt != 0) begin
            mv_cnt <= mv_cnt - 1;
            if (mv_cnt == 1) begin
                cmpl_valid <= 1'b1;
                cmpl_bytes <= mv_bytes;
                cmpl_err   <= mv_err;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_desc(input logic [AW-1:0] a, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w2,
                             input logic [31:0] w3);
        logic [31:0] w [4];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            ld_en   = 1'b1;
            ld_addr = a + AW'(i);
            ld_data = w[i];
            tick();
        end
        ld_en = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] h);
        start    = 1'b1;
        head_ptr = h;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done_irq, run_err, desc_read, desc_write, cmd_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, done_irq, run_err, desc_read, desc_write, cmd_valid});
        end
        checks++;
        if ({desc_address, desc_writedata} !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr %h data %h want 0", desc_address, desc_writedata);
        end
        checks++;
        if ({cmd_src, cmd_dst, cmd_len} !== '0) begin
            errors++;
            $display("FAIL reset_cmd: got %h %h %h want 0", cmd_src, cmd_dst, cmd_len);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int cb = cmd_n, wb = wr_n, ib = irq_n, lat = 1;
        bit ok;
        cmd_ready = 1'b0;
        load_desc(10'h010, 32'h1000, 32'h2000, 32'h0, 32'hE000_0040);
        do_start(10'h010);
        while (!cmd_valid && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles want 10", lat);
        end
        repeat (3) tick();
        checks++;
        if ({cmd_valid, cmd_src, cmd_dst, cmd_len} !== {1'b1, 32'h1000, 32'h2000, 16'h0040}) begin
            errors++;
            $display("FAIL single_hold: got %b %h %h %h want 1 1000 2000 0040",
                     cmd_valid, cmd_src, cmd_dst, cmd_len);
        end
        cmd_ready = 1'b1;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout: busy %b want 0", busy);
        end
        checks++;
        if (cmd_n - cb != 1 || {cmd_src_log[cb % 64], cmd_dst_log[cb % 64], cmd_len_log[cb % 64]}
            !== {32'h1000, 32'h2000, 16'h0040}) begin
            errors++;
            $display("FAIL single_cmd: count %0d %h %h %h want 1 1000 2000 0040", cmd_n - cb,
                     cmd_src_log[cb % 64], cmd_dst_log[cb % 64], cmd_len_log[cb % 64]);
        end
        checks++;
        if (wr_n - wb != 1 || wr_log_addr[wb % 64] !== 10'h013
            || wr_log_data[wb % 64] !== 32'h6000_0040) begin
            errors++;
            $display("FAIL single_wb: count %0d addr %h data %h want 1 013 60000040",
                     wr_n - wb, wr_log_addr[wb % 64], wr_log_data[wb % 64]);
        end
        checks++;
        if (irq_n - ib != 1 || run_err !== 1'b0) begin
            errors++;
            $display("FAIL single_irq: irqs %0d run_err %b want 1 0", irq_n - ib, run_err);
        end
    endtask

    task automatic test_chain();
        int cb = cmd_n, wb = wr_n, ib = irq_n;
        bit ok;
        logic [31:0]   es [3];
        logic [AW-1:0] ea [3];
        logic [31:0]   ed [3];
        es = '{32'hA000, 32'hA100, 32'hA200};
        ea = '{10'h003, 10'h023, 10'h3FF};
        ed = '{32'h0000_0010, 32'h2000_0020, 32'h4000_0030};
        load_desc(10'h000, 32'hA000, 32'hB000, 32'h021, 32'h8000_0010);
        load_desc(10'h020, 32'hA100, 32'hB100, 32'h3FE, 32'hA000_0020);
        load_desc(10'h3FC, 32'hA200, 32'hB200, 32'h000, 32'hC000_0030);
        wait_mode = 1'b1;
        do_start(10'h001);
        wait_idle(ok);
        wait_mode = 1'b0;
        checks++;
        if (!ok || cmd_n - cb != 3 || wr_n - wb != 3) begin
            errors++;
            $display("FAIL chain_counts: cmds %0d wbs %0d want 3 3", cmd_n - cb, wr_n - wb);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cmd_src_log[(cb + i) % 64] !== es[i] || wr_log_addr[(wb + i) % 64] !== ea[i]
                || wr_log_data[(wb + i) % 64] !== ed[i]) begin
                errors++;
                $display("FAIL chain_%0d: src %h wb %h=%h want %h %h=%h", i,
                         cmd_src_log[(cb + i) % 64], wr_log_addr[(wb + i) % 64],
                         wr_log_data[(wb + i) % 64], es[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (irq_n - ib != 1 || run_err !== 1'b0 || be_bad != 0) begin
            errors++;
            $display("FAIL chain_end: irqs %0d run_err %b bad_be %0d want 1 0 0",
                     irq_n - ib, run_err, be_bad);
        end
    endtask

    task automatic test_own_end();
        int cb = cmd_n, wb = wr_n, ib = irq_n, rb = rd_n;
        bit ok;
        load_desc(10'h040, 32'h4000, 32'h5000, 32'h080, 32'h8000_0008);
        load_desc(10'h080, 32'h0, 32'h0, 32'h0, 32'h0000_0000);
        do_start(10'h040);
        wait_idle(ok);
        checks++;
        if (!ok || cmd_n - cb != 1 || rd_n - rb != 8) begin
            errors++;
            $display("FAIL own_counts: cmds %0d reads %0d want 1 8", cmd_n - cb, rd_n - rb);
        end
        checks++;
        if (wr_n - wb != 1 || wr_log_addr[wb % 64] !== 10'h043
            || wr_log_data[wb % 64] !== 32'h0000_0008) begin
            errors++;
            $display("FAIL own_wb: count %0d addr %h data %h want 1 043 00000008",
                     wr_n - wb, wr_log_addr[wb % 64], wr_log_data[wb % 64]);
        end
        checks++;
        if (irq_n - ib != 0 || run_err !== 1'b0) begin
            errors++;
            $display("FAIL own_irq: irqs %0d run_err %b want 0 0", irq_n - ib, run_err);
        end
    endtask

    task automatic test_error();
        int cb = cmd_n, wb = wr_n, ib = irq_n;
        bit ok;
        load_desc(10'h100, 32'h6000, 32'h7000, 32'h104, 32'h8000_0050);
        load_desc(10'h104, 32'h6100, 32'h7100, 32'h000, 32'hC000_0010);
        err_idx    = cmd_n;
        byte_short = 16'h0010;
        do_start(10'h100);
        wait_idle(ok);
        err_idx    = -1;
        byte_short = '0;
        checks++;
        if (!ok || cmd_n - cb != 1 || cmd_len_log[cb % 64] !== 16'h0050) begin
            errors++;
            $display("FAIL err_cmd: cmds %0d len %h want 1 0050", cmd_n - cb,
                     cmd_len_log[cb % 64]);
        end
        checks++;
        if (wr_n - wb != 1 || wr_log_addr[wb % 64] !== 10'h103
            || wr_log_data[wb % 64] !== 32'h1000_0040) begin
            errors++;
            $display("FAIL err_wb: count %0d addr %h data %h want 1 103 10000040",
                     wr_n - wb, wr_log_addr[wb % 64], wr_log_data[wb % 64]);
        end
        checks++;
        if (irq_n - ib != 1 || run_err !== 1'b1) begin
            errors++;
            $display("FAIL err_flags: irqs %0d run_err %b want 1 1", irq_n - ib, run_err);
        end
    endtask

    task automatic test_max_chain();
        int cb = cmd_n, wb = wr_n, ib = irq_n, rb = rd_n, n = 0;
        bit ok;
        load_desc(10'h200, 32'h8000, 32'h9000, 32'h200, 32'h8000_0004);
        load_desc(10'h300, 32'h0, 32'h0, 32'h0, 32'h0);
        wr_protect = 1'b1;
        do_start(10'h200);
        checks++;
        if (run_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL max_start: run_err %b busy %b want 0 1", run_err, busy);
        end
        while (cmd_n - cb < 2 && n < 200) begin
            tick();
            n++;
        end
        do_start(10'h300);
        wait_idle(ok);
        wr_protect = 1'b0;
        checks++;
        if (!ok || cmd_n - cb != 4 || wr_n - wb != 4 || rd_n - rb != 20) begin
            errors++;
            $display("FAIL max_counts: cmds %0d wbs %0d reads %0d want 4 4 20",
                     cmd_n - cb, wr_n - wb, rd_n - rb);
        end
        checks++;
        if (wr_log_addr[(wb + 3) % 64] !== 10'h203 || wr_log_data[(wb + 3) % 64] !== 32'h4) begin
            errors++;
            $display("FAIL max_wb: addr %h data %h want 203 00000004",
                     wr_log_addr[(wb + 3) % 64], wr_log_data[(wb + 3) % 64]);
        end
        checks++;
        if (irq_n - ib != 1 || run_err !== 1'b1) begin
            errors++;
            $display("FAIL max_flags: irqs %0d run_err %b want 1 1", irq_n - ib, run_err);
        end
    endtask

    task automatic test_stop();
        int cb = cmd_n, wb = wr_n, ib = irq_n, rb = rd_n, n = 0;
        bit ok;
        load_desc(10'h140, 32'hC000, 32'hD000, 32'h144, 32'h8000_0020);
        load_desc(10'h144, 32'hC100, 32'hD100, 32'h148, 32'h8000_0020);
        load_desc(10'h148, 32'hC200, 32'hD200, 32'h000, 32'hC000_0020);
        cmpl_delay = 6;
        do_start(10'h140);
        while (cmd_n == cb && n < 60) begin
            tick();
            n++;
        end
        stop = 1'b1;
        wait_idle(ok);
        stop       = 1'b0;
        cmpl_delay = 3;
        checks++;
        if (!ok || cmd_n - cb != 1 || rd_n - rb != 8) begin
            errors++;
            $display("FAIL stop_counts: cmds %0d reads %0d want 1 8", cmd_n - cb, rd_n - rb);
        end
        checks++;
        if (wr_n - wb != 1 || wr_log_addr[wb % 64] !== 10'h143
            || wr_log_data[wb % 64] !== 32'h0000_0020) begin
            errors++;
            $display("FAIL stop_wb: count %0d addr %h data %h want 1 143 00000020",
                     wr_n - wb, wr_log_addr[wb % 64], wr_log_data[wb % 64]);
        end
        checks++;
        if (irq_n - ib != 0 || run_err !== 1'b0) begin
            errors++;
            $display("FAIL stop_flags: irqs %0d run_err %b want 0 0", irq_n - ib, run_err);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        cmd_ready = 1'b0;
        load_desc(10'h010, 32'h1000, 32'h2000, 32'h0, 32'hE000_0040);
        do_start(10'h010);
        while (!cmd_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_issue: cmd_valid %b want 1", cmd_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, busy, desc_read} !== 3'b000 || cmd_src !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: valid %b busy %b read %b src %h want 0 0 0 0",
                     cmd_valid, busy, desc_read, cmd_src);
        end
        tick();
        reset_n   = 1'b1;
        cmd_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_own_end();
        test_error();
        test_max_chain();
        test_stop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
